// File: rtl/dice_pkg.sv
// Shared constants for the dice game core: FSM encoding, LFSR taps, die-face limits.
package dice_pkg;

    localparam int unsigned LFSR_W = 16;
    localparam int unsigned FACE_W = 3;
    localparam int unsigned ST_W   = 3;

    // Fibonacci taps 16,14,13,11 expressed as a bit mask over lfsr[15:0]
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    // Usable die faces; raw samples of 0 and 7 fall outside and are resampled
    localparam logic [FACE_W-1:0] FACE_MIN = 3'd1;
    localparam logic [FACE_W-1:0] FACE_MAX = 3'd6;

    localparam logic [ST_W-1:0] ST_IDLE      = 3'd0;
    localparam logic [ST_W-1:0] ST_WAIT_IN   = 3'd1;
    localparam logic [ST_W-1:0] ST_ROLL_RES  = 3'd2;
    localparam logic [ST_W-1:0] ST_HOLD_RES  = 3'd3;
    localparam logic [ST_W-1:0] ST_NEXT      = 3'd4;
    localparam logic [ST_W-1:0] ST_GAME_OVER = 3'd5;

    // One-cycle button events after synchronisation and edge detection
    typedef struct packed {
        logic new_game;
        logic roll;
        logic hold;
    } btn_pulse_t;

    // One LFSR step: shift left, feedback is the XOR of the tapped bits
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
    endfunction

    // True when a raw 3-bit sample is a legal die face
    function automatic logic face_valid(input logic [FACE_W-1:0] v);
        return (v >= FACE_MIN) && (v <= FACE_MAX);
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchroniser followed by a rising-edge detector for one raw button.
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic rise_c_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Synchroniser chain plus delayed copy used for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Combinational so the FSM sees the press on the cycle the synchronised level rises
    assign rise_c_o = sync2_q & ~prev_q;

endmodule

// File: rtl/dice_game_core.sv
// Multi-player "pig" dice game: button conditioning, LFSR die, turn/score FSM.
module dice_game_core
    import dice_pkg::*;
#(
    parameter int unsigned       N_PLAYERS = 2,
    parameter int unsigned       SCORE_W   = 7,
    parameter int unsigned       TARGET    = 100,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic                           NEW_GAME,
    input  logic                           ROLL,
    input  logic                           HOLD,
    output logic [FACE_W-1:0]              dice,
    output logic [SCORE_W-1:0]             turn_sum,
    output logic [N_PLAYERS*SCORE_W-1:0]   scores,
    output logic [2:0]                     player,
    output logic                           ready,
    output logic                           win
);

    localparam int unsigned       SCORES_W    = N_PLAYERS * SCORE_W;
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
    localparam logic [SCORE_W-1:0] TARGET_V   = SCORE_W'(TARGET);
    localparam logic [2:0]         PLAYER_LAST = 3'(N_PLAYERS - 1);

    // Unsigned add clamped to the all-ones score value
    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [SCORE_W-1:0] b);
        logic [SCORE_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[SCORE_W] ? SCORE_MAX : s[SCORE_W-1:0];
    endfunction

    logic          ng_rise;
    logic          roll_rise;
    logic          hold_rise;
    btn_pulse_t    btn_c;

    logic [ST_W-1:0]     state_q,    state_d;
    logic [LFSR_W-1:0]   lfsr_q;
    logic [FACE_W-1:0]   dice_q,     dice_d;
    logic [SCORE_W-1:0]  turn_sum_q, turn_sum_d;
    logic [SCORES_W-1:0] scores_q,   scores_d;
    logic [2:0]          player_q,   player_d;
    logic                ready_q;
    logic                win_q;

    logic [SCORE_W-1:0]  cur_score;
    logic [SCORE_W-1:0]  bank_sum;
    logic [FACE_W-1:0]   roll_val;

    btn_edge u_ng_edge (
        .clk      (CLK),
        .rst_n    (RESET),
        .btn_i    (NEW_GAME),
        .rise_c_o (ng_rise)
    );

    btn_edge u_roll_edge (
        .clk      (CLK),
        .rst_n    (RESET),
        .btn_i    (ROLL),
        .rise_c_o (roll_rise)
    );

    btn_edge u_hold_edge (
        .clk      (CLK),
        .rst_n    (RESET),
        .btn_i    (HOLD),
        .rise_c_o (hold_rise)
    );

    assign btn_c = '{new_game: ng_rise, roll: roll_rise, hold: hold_rise};

    // Free-running die source; keeps stepping even after the game ends
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    // Next-state and datapath decisions; NEW_GAME overrides everything
    always_comb begin
        state_d    = state_q;
        dice_d     = dice_q;
        turn_sum_d = turn_sum_q;
        scores_d   = scores_q;
        player_d   = player_q;
        roll_val   = lfsr_q[FACE_W-1:0];

        cur_score = '0;
        for (int unsigned p = 0; p < N_PLAYERS; p++) begin
            if (player_q == 3'(p)) begin
                cur_score = scores_q[p*SCORE_W +: SCORE_W];
            end
        end
        bank_sum = sat_add(cur_score, turn_sum_q);

        if (btn_c.new_game) begin
            state_d    = ST_WAIT_IN;
            dice_d     = '0;
            turn_sum_d = '0;
            scores_d   = '0;
            player_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_WAIT_IN: begin
                    // ROLL wins a tie with HOLD; the HOLD event is simply dropped
                    if (btn_c.roll) begin
                        state_d = ST_ROLL_RES;
                    end else if (btn_c.hold) begin
                        state_d = ST_HOLD_RES;
                    end
                end
                ST_ROLL_RES: begin
                    // Illegal samples leave the state unchanged so the next LFSR value is tried
                    if (face_valid(roll_val)) begin
                        dice_d = roll_val;
                        if (roll_val == FACE_MIN) begin
                            turn_sum_d = '0;
                            state_d    = ST_NEXT;
                        end else begin
                            turn_sum_d = sat_add(turn_sum_q, SCORE_W'(roll_val));
                            state_d    = ST_WAIT_IN;
                        end
                    end
                end
                ST_HOLD_RES: begin
                    for (int unsigned p = 0; p < N_PLAYERS; p++) begin
                        if (player_q == 3'(p)) begin
                            scores_d[p*SCORE_W +: SCORE_W] = bank_sum;
                        end
                    end
                    turn_sum_d = '0;
                    state_d    = (bank_sum >= TARGET_V) ? ST_GAME_OVER : ST_NEXT;
                end
                ST_NEXT: begin
                    player_d = (player_q >= PLAYER_LAST) ? 3'd0 : player_q + 3'd1;
                    dice_d   = '0;
                    state_d  = ST_WAIT_IN;
                end
                ST_GAME_OVER: begin
                    state_d = ST_GAME_OVER;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, game datapath and registered status flags
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ST_IDLE;
            dice_q     <= '0;
            turn_sum_q <= '0;
            scores_q   <= '0;
            player_q   <= '0;
            ready_q    <= 1'b0;
            win_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            dice_q     <= dice_d;
            turn_sum_q <= turn_sum_d;
            scores_q   <= scores_d;
            player_q   <= player_d;
            ready_q    <= (state_d == ST_WAIT_IN);
            win_q      <= (state_d == ST_GAME_OVER);
        end
    end

    assign dice     = dice_q;
    assign turn_sum = turn_sum_q;
    assign scores   = scores_q;
    assign player   = player_q;
    assign ready    = ready_q;
    assign win      = win_q;

endmodule
